// File: rtl/sr_cmd_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_cmd_pkg
// Description : Shared types and constants for the SR command generator.
//               - dbnc_state_t    : per-button debounce state, 2-bit encoding
//               - DBNC_CYCLES_DEF : default qualification length (10 ms @ 100 MHz)
//               - DBNC_SIM        : short qualification length for simulation
// Revision    : 1.0 - initial release
// ============================================================================
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // debounced low
    WAIT_HI = 2'd1,  // rising, qualifying
    PRESSED = 2'd2,  // debounced high
    WAIT_LO = 2'd3   // falling, qualifying
  } dbnc_state_t;

  localparam int DBNC_CYCLES_DEF = 1_000_000;
  localparam int DBNC_SIM        = 4;

endpackage : sr_cmd_pkg
`default_nettype wire

// File: rtl/sr_cmd_gen_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser, four-state debounce FSM and
//               qualification counter for one raw pushbutton.
// Ports       : clk       in  system clock, rising edge
//               rst       in  synchronous reset, active-low
//               btn       in  raw asynchronous button, active-high
//               press_evt out registered one-cycle pulse on accepted press
//               deb_level out debounced level (high in PRESSED / WAIT_LO)
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DBNC_CYCLES = DBNC_CYCLES_DEF,
  parameter int CNT_W       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_evt,
  output logic deb_level
);

  // Terminal count: the level must be seen for DBNC_CYCLES consecutive
  // cycles in a WAIT state (count 0 .. DBNC_CYCLES-1) before it is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

  logic             sy1;
  logic             sy2;
  dbnc_state_t      state;
  dbnc_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             evt_nxt;

  // Synchroniser, state, counter and event register
  always_ff @(posedge clk) begin
    if (!rst) begin
      sy1       <= 1'b0;
      sy2       <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      sy1       <= btn;
      sy2       <= sy1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      press_evt <= evt_nxt;
    end
  end

  // Next-state logic. The counter is cleared on every state change so it
  // sits at zero in IDLE/PRESSED and only advances inside a WAIT state,
  // where it stops at CNT_LAST and therefore can never wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    evt_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (sy2) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!sy2) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          evt_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!sy2) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (sy2) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          // Release is accepted silently; only presses generate events.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign deb_level = (state == PRESSED) || (state == WAIT_LO);

endmodule : btn_debounce
`default_nettype wire

// File: rtl/sr_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : sr_cmd_gen
// Description : Turns two raw pushbuttons into clean, mutually exclusive
//               set/reset commands for the downstream SR flip-flop.
//               Each button is synchronised and debounced by btn_debounce;
//               this level only arbitrates and registers the outputs.
// Config      : SR_CMD_PULSE_EN defined -> s/r are one-cycle pulses on
//               press events, err pulses when both press in the same cycle.
//               Undefined (default)     -> level mode, s/r follow the
//               debounced levels, err held while both are high.
// Ports       : clk     in  system clock, rising edge
//               rst     in  synchronous reset, active-low
//               btn_set in  raw set pushbutton, active-high
//               btn_rst in  raw reset pushbutton, active-high
//               s       out registered set command
//               r       out registered reset command
//               err     out registered conflict flag
// Revision    : 1.0 - initial release
// ============================================================================
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DBNC_CYCLES = DBNC_CYCLES_DEF,
  parameter int CNT_W       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_rst,
  output logic s,
  output logic r,
  output logic err
);

  logic set_evt;
  logic rst_evt;
  logic set_lvl;
  logic rst_lvl;
  logic s_nxt;
  logic r_nxt;
  logic err_nxt;

  btn_debounce #(
    .DBNC_CYCLES (DBNC_CYCLES),
    .CNT_W       (CNT_W)
  ) u_dbnc_set (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn_set),
    .press_evt (set_evt),
    .deb_level (set_lvl)
  );

  btn_debounce #(
    .DBNC_CYCLES (DBNC_CYCLES),
    .CNT_W       (CNT_W)
  ) u_dbnc_rst (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn_rst),
    .press_evt (rst_evt),
    .deb_level (rst_lvl)
  );

  // Arbitration: a command is issued only when the other side is quiet,
  // so s and r can never be high together; overlap raises err instead.
`ifdef SR_CMD_PULSE_EN
  // Debounced levels are not needed here; sink them explicitly.
  logic unused_lvl;
  assign unused_lvl = set_lvl ^ rst_lvl;

  always_comb begin
    s_nxt   = set_evt & ~rst_evt;
    r_nxt   = rst_evt & ~set_evt;
    err_nxt = set_evt &  rst_evt;
  end
`else
  // Press events are not needed here; sink them explicitly.
  logic unused_evt;
  assign unused_evt = set_evt ^ rst_evt;

  always_comb begin
    s_nxt   = set_lvl & ~rst_lvl;
    r_nxt   = rst_lvl & ~set_lvl;
    err_nxt = set_lvl &  rst_lvl;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      s   <= 1'b0;
      r   <= 1'b0;
      err <= 1'b0;
    end else begin
      s   <= s_nxt;
      r   <= r_nxt;
      err <= err_nxt;
    end
  end

endmodule : sr_cmd_gen
`default_nettype wire

// File: tb/tb_sr_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_cmd_gen
// Description : Directed self-checking bench for sr_cmd_gen with a 4-cycle
//               debounce. Inputs are applied just after a rising edge and
//               take effect at the next one; outputs are sampled 1 time unit
//               after each rising edge. Edge n of each scenario is the n-th
//               rising edge of its stimulus loop. Expected s/r/err windows
//               are hand-derived for both pulse and level builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_cmd_gen;
  import sr_cmd_pkg::*;

`ifdef SR_CMD_PULSE_EN
  localparam bit PULSE_MODE = 1'b1;
`else
  localparam bit PULSE_MODE = 1'b0;
`endif

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic btn_set = 1'b0;
  logic btn_rst = 1'b0;
  logic s;
  logic r;
  logic err;

  int total = 0;
  int bad   = 0;

  sr_cmd_gen #(
    .DBNC_CYCLES (DBNC_SIM),
    .CNT_W       (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_set (btn_set),
    .btn_rst (btn_rst),
    .s       (s),
    .r       (r),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    btn_set = 1'b0;
    btn_rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Reset held 2 edges with both buttons high; afterwards only btn_set
  // stays high, so it is first sampled at edge 3 and s appears after edge 10.
  task automatic test_reset();
    logic exp_s;
    for (int n = 1; n <= 30; n++) begin
      rst     = (n >= 3);
      btn_rst = (n <= 2);
      btn_set = (n <= 20);
      tick();
      exp_s = PULSE_MODE ? (n == 10) : (n >= 10 && n <= 27);
      total++;
      if (s !== exp_s) begin
        bad++;
        $display("FAIL reset_s edge=%0d got=%b exp=%b", n, s, exp_s);
      end
      total++;
      if (r !== 1'b0) begin
        bad++;
        $display("FAIL reset_r edge=%0d got=%b exp=0", n, r);
      end
      total++;
      if (err !== 1'b0) begin
        bad++;
        $display("FAIL reset_err edge=%0d got=%b exp=0", n, err);
      end
    end
  endtask

  // Clean press held 20 edges: s after edge 8; level mode releases after 27.
  task automatic test_clean_set();
    logic exp_s;
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      btn_set = (n <= 20);
      btn_rst = 1'b0;
      tick();
      exp_s = PULSE_MODE ? (n == 8) : (n >= 8 && n <= 27);
      total++;
      if (s !== exp_s) begin
        bad++;
        $display("FAIL clean_s edge=%0d got=%b exp=%b", n, s, exp_s);
      end
      total++;
      if (r !== 1'b0) begin
        bad++;
        $display("FAIL clean_r edge=%0d got=%b exp=0", n, r);
      end
      total++;
      if (err !== 1'b0) begin
        bad++;
        $display("FAIL clean_err edge=%0d got=%b exp=0", n, err);
      end
    end
  endtask

  // Bounce 1,0,1,1,0 then stable from edge 6 to 25: s after edge 13.
  task automatic test_bounce();
    logic       exp_s;
    logic [4:0] bpat;
    bpat = 5'b01101;
    do_reset();
    for (int n = 1; n <= 36; n++) begin
      if (n <= 5) btn_set = bpat[n-1];
      else        btn_set = (n <= 25);
      btn_rst = 1'b0;
      tick();
      exp_s = PULSE_MODE ? (n == 13) : (n >= 13 && n <= 32);
      total++;
      if (s !== exp_s) begin
        bad++;
        $display("FAIL bounce_s edge=%0d got=%b exp=%b", n, s, exp_s);
      end
      total++;
      if (r !== 1'b0) begin
        bad++;
        $display("FAIL bounce_r edge=%0d got=%b exp=0", n, r);
      end
      total++;
      if (err !== 1'b0) begin
        bad++;
        $display("FAIL bounce_err edge=%0d got=%b exp=0", n, err);
      end
    end
  endtask

  // Both buttons rise together: no commands, err after edge 8.
  task automatic test_simultaneous();
    logic exp_e;
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      btn_set = (n <= 20);
      btn_rst = (n <= 20);
      tick();
      exp_e = PULSE_MODE ? (n == 8) : (n >= 8 && n <= 27);
      total++;
      if (s !== 1'b0) begin
        bad++;
        $display("FAIL simul_s edge=%0d got=%b exp=0", n, s);
      end
      total++;
      if (r !== 1'b0) begin
        bad++;
        $display("FAIL simul_r edge=%0d got=%b exp=0", n, r);
      end
      total++;
      if (err !== exp_e) begin
        bad++;
        $display("FAIL simul_err edge=%0d got=%b exp=%b", n, err, exp_e);
      end
    end
  endtask

  // btn_set edges 1..20, btn_rst edges 3..22. Set level after 7..26,
  // reset level after 9..28; the registered outputs follow one edge later.
  task automatic test_staggered();
    logic exp_s;
    logic exp_r;
    logic exp_e;
    do_reset();
    for (int n = 1; n <= 34; n++) begin
      btn_set = (n <= 20);
      btn_rst = (n >= 3 && n <= 22);
      tick();
      exp_s = PULSE_MODE ? (n == 8)  : (n >= 8  && n <= 9);
      exp_r = PULSE_MODE ? (n == 10) : (n >= 28 && n <= 29);
      exp_e = PULSE_MODE ? 1'b0      : (n >= 10 && n <= 27);
      total++;
      if (s !== exp_s) begin
        bad++;
        $display("FAIL stagger_s edge=%0d got=%b exp=%b", n, s, exp_s);
      end
      total++;
      if (r !== exp_r) begin
        bad++;
        $display("FAIL stagger_r edge=%0d got=%b exp=%b", n, r, exp_r);
      end
      total++;
      if (err !== exp_e) begin
        bad++;
        $display("FAIL stagger_err edge=%0d got=%b exp=%b", n, err, exp_e);
      end
      total++;
      if ((s & r) !== 1'b0) begin
        bad++;
        $display("FAIL stagger_excl edge=%0d got s=%b r=%b exp not both", n, s, r);
      end
    end
  endtask

  // btn_set held from edge 1, reset at edge 5 while in WAIT_HI: the partial
  // count is lost, the button is re-sampled at edge 6, s after edge 13.
  task automatic test_reset_midcount();
    logic exp_s;
    do_reset();
    for (int n = 1; n <= 36; n++) begin
      rst     = (n != 5);
      btn_set = (n <= 25);
      btn_rst = 1'b0;
      tick();
      exp_s = PULSE_MODE ? (n == 13) : (n >= 13 && n <= 32);
      total++;
      if (s !== exp_s) begin
        bad++;
        $display("FAIL midrst_s edge=%0d got=%b exp=%b", n, s, exp_s);
      end
      total++;
      if (r !== 1'b0) begin
        bad++;
        $display("FAIL midrst_r edge=%0d got=%b exp=0", n, r);
      end
      total++;
      if (err !== 1'b0) begin
        bad++;
        $display("FAIL midrst_err edge=%0d got=%b exp=0", n, err);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_set();
    test_bounce();
    test_simultaneous();
    test_staggered();
    test_reset_midcount();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sr_cmd_gen
`default_nettype wire
